// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 2:1 data mux with one-hot grants.
// A per-ownership beat quota forces re-arbitration after MAX_BEATS transfers.
//
// state | meaning
// IDLE  | no owner, gnt=00, sel=0
// OWN0  | requester 0 owns the output, gnt=01, sel=0
// OWN1  | requester 1 owns the output, gnt=10, sel=1
module mux_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            own;
  logic            other;
  logic            beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign own   = (state_q == OWN1);
  assign other = ~own;
  assign beat  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // last_q=1 hands a tie to requester 0
        if (req[0] && (!req[1] || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req[1]) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!req[own]) begin
          cnt_d = '0;
          if (req[other]) begin
            state_d = own ? OWN0 : OWN1;
            last_d  = other;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (req[other]) begin
              state_d = own ? OWN0 : OWN1;
              last_d  = other;
            end else begin
              last_d  = own;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b1;
      end
    endcase
  end

  assign gnt       = {state_q == OWN1, state_q == OWN0};
  assign sel       = (state_q == OWN1);
  assign out_valid = gnt[sel] & req[sel];
  assign out_data  = sel ? data1 : data0;

endmodule
